// File: rtl/ice_sl_msg_tx.sv
// ice_sl_msg_tx: slave-side message transmitter for the ICE internal bus.
// Buffers one producer message, arbitrates for the shared sl_* bus and emits
// the frame as ADDR (type + time tag), DATA (payload bytes) and TAIL (status).
module ice_sl_msg_tx #(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_evt_type,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    input  logic       wr_last,
    output logic       wr_ready,
    input  logic [7:0] global_counter,
    output logic       ctr_incr,
    input  logic       sl_overflow,
    output logic       sl_arb_request,
    input  logic       sl_arb_grant,
    output logic [8:0] sl_addr,
    output logic [8:0] sl_data,
    output logic [8:0] sl_tail,
    output logic       sl_latch_tail,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_FILL,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_TAIL
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

    state_t     state;
    logic [7:0] buf_mem [DEPTH];
    logic [7:0] count;
    logic [7:0] idx;
    logic [7:0] evt_type;
    logic [7:0] evt_id;
    logic       trunc;
    logic       abort;
    logic       gnt_q;

    logic       hs;
    logic       fill_end;
    logic       emit;

    // A byte is taken only while filling; the last slot forces the message closed.
    assign wr_ready = (state == S_FILL);
    assign hs       = wr_valid & wr_ready;
    assign fill_end = wr_last | (count == LAST_IDX);
    assign ctr_incr = hs & fill_end & ~reset;

    // Emission needs grant now and in the previous cycle, so a returning grant
    // resumes output one cycle later.
    assign emit = sl_arb_grant & gnt_q;

    assign sl_arb_request = (state != S_FILL);
    assign busy           = (state != S_FILL) | (count != 8'd0);

    // Control path: message FSM, fill count, emit index and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FILL;
            count <= 8'd0;
            idx   <= 8'd0;
            trunc <= 1'b0;
            abort <= 1'b0;
            gnt_q <= 1'b0;
        end else begin
            gnt_q <= sl_arb_grant;
            case (state)
                S_FILL: begin
                    if (hs) begin
                        count <= count + 8'd1;
                        if (fill_end) begin
                            trunc <= ~wr_last;
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (sl_arb_grant) state <= S_ADDR;
                end
                S_ADDR: begin
                    if (emit) begin
                        idx <= 8'd0;
                        if (sl_overflow) begin
                            abort <= 1'b1;
                            state <= S_TAIL;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (emit) begin
                        idx <= idx + 8'd1;
                        if (sl_overflow) begin
                            abort <= 1'b1;
                            state <= S_TAIL;
                        end else if (idx == count - 8'd1) begin
                            state <= S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    state <= S_FILL;
                    count <= 8'd0;
                    idx   <= 8'd0;
                    trunc <= 1'b0;
                    abort <= 1'b0;
                end
                default: state <= S_FILL;
            endcase
        end
    end

    // Data path: payload buffer, event type and time tag captured on handshakes.
    always_ff @(posedge clk) begin
        if (hs) begin
            buf_mem[count[PTR_W-1:0]] <= wr_data;
            if (count == 8'd0) evt_type <= wr_evt_type;
            if (fill_end) evt_id <= global_counter;
        end
    end

    // Bus drive: all-zero unless actively emitting, so slaves can be wired-OR'd.
    always_comb begin
        sl_addr       = 9'd0;
        sl_data       = 9'd0;
        sl_tail       = 9'd0;
        sl_latch_tail = 1'b0;
        case (state)
            S_ADDR: begin
                if (emit) begin
                    sl_addr = {1'b1, evt_type};
                    sl_data = {1'b1, evt_id};
                end
            end
            S_DATA: begin
                if (emit) sl_data = {1'b1, buf_mem[idx[PTR_W-1:0]]};
            end
            S_TAIL: begin
                sl_latch_tail = 1'b1;
                sl_tail       = {trunc | abort, idx};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ice_sl_msg_tx.sv
// Directed testbench for ice_sl_msg_tx: a DEPTH=64 instance for the frame,
// grant, overflow and reset scenarios, and a DEPTH=4 instance for truncation.
module tb_ice_sl_msg_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_evt_type = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_valid = 1'b0;
    logic       wr_valid4 = 1'b0;
    logic       wr_last = 1'b0;
    logic [7:0] global_counter = 8'd0;
    logic       sl_overflow = 1'b0;
    logic       sl_arb_grant = 1'b0;

    logic       wr_ready, ctr_incr, sl_arb_request, sl_latch_tail, busy;
    logic [8:0] sl_addr, sl_data, sl_tail;
    logic       wr_ready4, ctr_incr4, sl_arb_request4, sl_latch_tail4, busy4;
    logic [8:0] sl_addr4, sl_data4, sl_tail4;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] msg [8];

    ice_sl_msg_tx #(.DEPTH(64), .PTR_W(6)) dut (
        .clk(clk), .reset(reset),
        .wr_evt_type(wr_evt_type), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_last(wr_last), .wr_ready(wr_ready),
        .global_counter(global_counter), .ctr_incr(ctr_incr),
        .sl_overflow(sl_overflow), .sl_arb_request(sl_arb_request),
        .sl_arb_grant(sl_arb_grant), .sl_addr(sl_addr), .sl_data(sl_data),
        .sl_tail(sl_tail), .sl_latch_tail(sl_latch_tail), .busy(busy)
    );

    ice_sl_msg_tx #(.DEPTH(4), .PTR_W(2)) dut4 (
        .clk(clk), .reset(reset),
        .wr_evt_type(wr_evt_type), .wr_data(wr_data), .wr_valid(wr_valid4),
        .wr_last(wr_last), .wr_ready(wr_ready4),
        .global_counter(global_counter), .ctr_incr(ctr_incr4),
        .sl_overflow(sl_overflow), .sl_arb_request(sl_arb_request4),
        .sl_arb_grant(sl_arb_grant), .sl_addr(sl_addr4), .sl_data(sl_data4),
        .sl_tail(sl_tail4), .sl_latch_tail(sl_latch_tail4), .busy(busy4)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a message byte-by-byte on the DEPTH=64 instance; returns in the
    // cycle of the final handshake with inputs still applied.
    task automatic write_msg(input logic [7:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            wr_evt_type = t;
            wr_data     = msg[i];
            wr_valid    = 1'b1;
            wr_last     = (i == n - 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        checks++; if ({sl_addr, sl_data, sl_tail, sl_latch_tail} !== 28'd0) begin
            errors++; $display("FAIL reset_bus: got %h %h %h %b, expected all zero", sl_addr, sl_data, sl_tail, sl_latch_tail); end
        checks++; if (sl_arb_request !== 1'b0) begin
            errors++; $display("FAIL reset_request: got %b, expected 0", sl_arb_request); end
        checks++; if (ctr_incr !== 1'b0) begin
            errors++; $display("FAIL reset_ctr_incr: got %b, expected 0", ctr_incr); end
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wr_ready: got %b, expected 1", wr_ready); end
        checks++; if ({wr_ready4, sl_arb_request4, busy4} !== 3'b100) begin
            errors++; $display("FAIL reset_d4: got %b, expected 100", {wr_ready4, sl_arb_request4, busy4}); end
    endtask

    task automatic test_basic_frame();
        global_counter = 8'h05;
        sl_arb_grant   = 1'b1;
        msg[0] = 8'hA1; msg[1] = 8'hA2; msg[2] = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            tick();
            wr_evt_type = 8'h12;
            wr_data     = msg[i];
            wr_valid    = 1'b1;
            wr_last     = (i == 2);
            #1;
            checks++; if (ctr_incr !== (i == 2)) begin
                errors++; $display("FAIL basic_ctr_incr[%0d]: got %b, expected %b", i, ctr_incr, (i == 2)); end
            checks++; if (wr_ready !== 1'b1) begin
                errors++; $display("FAIL basic_wr_ready[%0d]: got %b, expected 1", i, wr_ready); end
        end
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
        #1;
        checks++; if ({sl_arb_request, wr_ready, ctr_incr, busy} !== 4'b1001) begin
            errors++; $display("FAIL basic_req: got req/rdy/incr/busy %b, expected 1001", {sl_arb_request, wr_ready, ctr_incr, busy}); end
        checks++; if (sl_addr !== 9'h000) begin
            errors++; $display("FAIL basic_req_addr: got %h, expected 000", sl_addr); end
        tick(); #1;
        checks++; if (sl_addr !== 9'h112) begin
            errors++; $display("FAIL basic_addr: got %h, expected 112", sl_addr); end
        checks++; if (sl_data !== 9'h105) begin
            errors++; $display("FAIL basic_evt_id: got %h, expected 105", sl_data); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++; if (sl_data !== {1'b1, msg[i]} || sl_addr !== 9'h000) begin
                errors++; $display("FAIL basic_data[%0d]: got data %h addr %h, expected %h 000", i, sl_data, sl_addr, {1'b1, msg[i]}); end
        end
        tick(); #1;
        checks++; if (sl_latch_tail !== 1'b1 || sl_tail !== 9'h003 || sl_data !== 9'h000) begin
            errors++; $display("FAIL basic_tail: got latch %b tail %h data %h, expected 1 003 000", sl_latch_tail, sl_tail, sl_data); end
        tick(); #1;
        checks++; if ({sl_arb_request, sl_latch_tail, wr_ready, busy} !== 4'b0010) begin
            errors++; $display("FAIL basic_done: got req/latch/rdy/busy %b, expected 0010", {sl_arb_request, sl_latch_tail, wr_ready, busy}); end
    endtask

    task automatic test_grant_wait();
        global_counter = 8'h06;
        sl_arb_grant   = 1'b0;
        msg[0] = 8'h11; msg[1] = 8'h22;
        write_msg(8'h34, 2);
        for (int k = 0; k < 10; k++) begin
            tick();
            wr_valid       = 1'b1;
            wr_last        = 1'b1;
            wr_data        = 8'hEE;
            wr_evt_type    = 8'hEE;
            global_counter = 8'h99;
            #1;
            checks++; if ({sl_addr, sl_data, sl_tail, sl_latch_tail} !== 28'd0 || wr_ready !== 1'b0 || sl_arb_request !== 1'b1) begin
                errors++; $display("FAIL wait_idle[%0d]: got bus %h %h %h %b rdy %b req %b, expected zero bus rdy 0 req 1", k, sl_addr, sl_data, sl_tail, sl_latch_tail, wr_ready, sl_arb_request); end
        end
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
        sl_arb_grant = 1'b1;
        #1;
        checks++; if (sl_addr !== 9'h000) begin
            errors++; $display("FAIL wait_grant_cycle: got addr %h, expected 000", sl_addr); end
        tick(); #1;
        checks++; if (sl_addr !== 9'h134 || sl_data !== 9'h106) begin
            errors++; $display("FAIL wait_addr: got %h %h, expected 134 106", sl_addr, sl_data); end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            checks++; if (sl_data !== {1'b1, msg[i]}) begin
                errors++; $display("FAIL wait_data[%0d]: got %h, expected %h", i, sl_data, {1'b1, msg[i]}); end
        end
        tick(); #1;
        checks++; if (sl_latch_tail !== 1'b1 || sl_tail !== 9'h002) begin
            errors++; $display("FAIL wait_tail: got latch %b tail %h, expected 1 002", sl_latch_tail, sl_tail); end
        tick(); #1;
        checks++; if (sl_arb_request !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL wait_done: got req %b rdy %b, expected 0 1", sl_arb_request, wr_ready); end
    endtask

    task automatic test_grant_loss();
        global_counter = 8'h07;
        sl_arb_grant   = 1'b1;
        msg[0] = 8'hB1; msg[1] = 8'hB2; msg[2] = 8'hB3; msg[3] = 8'hB4;
        write_msg(8'h56, 4);
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
        tick(); #1;
        checks++; if (sl_addr !== 9'h156 || sl_data !== 9'h107) begin
            errors++; $display("FAIL loss_addr: got %h %h, expected 156 107", sl_addr, sl_data); end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            checks++; if (sl_data !== {1'b1, msg[i]}) begin
                errors++; $display("FAIL loss_data[%0d]: got %h, expected %h", i, sl_data, {1'b1, msg[i]}); end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            sl_arb_grant = (k == 3);
            #1;
            checks++; if ({sl_addr, sl_data, sl_tail, sl_latch_tail} !== 28'd0 || sl_arb_request !== 1'b1) begin
                errors++; $display("FAIL loss_gap[%0d]: got bus %h %h %h %b req %b, expected zero bus req 1", k, sl_addr, sl_data, sl_tail, sl_latch_tail, sl_arb_request); end
        end
        for (int i = 2; i < 4; i++) begin
            tick(); #1;
            checks++; if (sl_data !== {1'b1, msg[i]}) begin
                errors++; $display("FAIL loss_resume[%0d]: got %h, expected %h", i, sl_data, {1'b1, msg[i]}); end
        end
        tick(); #1;
        checks++; if (sl_latch_tail !== 1'b1 || sl_tail !== 9'h004 || sl_data !== 9'h000) begin
            errors++; $display("FAIL loss_tail: got latch %b tail %h data %h, expected 1 004 000", sl_latch_tail, sl_tail, sl_data); end
        tick(); #1;
        checks++; if (sl_arb_request !== 1'b0) begin
            errors++; $display("FAIL loss_done: got req %b, expected 0", sl_arb_request); end
    endtask

    task automatic test_overflow();
        global_counter = 8'h08;
        sl_arb_grant   = 1'b1;
        msg[0] = 8'hC1; msg[1] = 8'hC2; msg[2] = 8'hC3; msg[3] = 8'hC4; msg[4] = 8'hC5;
        write_msg(8'h78, 5);
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
        tick(); #1;
        checks++; if (sl_addr !== 9'h178 || sl_data !== 9'h108) begin
            errors++; $display("FAIL ovf_addr: got %h %h, expected 178 108", sl_addr, sl_data); end
        tick(); #1;
        checks++; if (sl_data !== 9'h1C1) begin
            errors++; $display("FAIL ovf_data0: got %h, expected 1c1", sl_data); end
        tick();
        sl_overflow = 1'b1;
        #1;
        checks++; if (sl_data !== 9'h1C2) begin
            errors++; $display("FAIL ovf_data1: got %h, expected 1c2", sl_data); end
        tick();
        sl_overflow = 1'b0;
        #1;
        checks++; if (sl_latch_tail !== 1'b1 || sl_tail !== 9'h102 || sl_data !== 9'h000) begin
            errors++; $display("FAIL ovf_tail: got latch %b tail %h data %h, expected 1 102 000", sl_latch_tail, sl_tail, sl_data); end
        tick(); #1;
        checks++; if ({sl_addr, sl_data, sl_tail, sl_latch_tail} !== 28'd0 || sl_arb_request !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ovf_done: got bus %h %h %h %b req %b busy %b, expected idle", sl_addr, sl_data, sl_tail, sl_latch_tail, sl_arb_request, busy); end
    endtask

    task automatic test_truncation();
        global_counter = 8'h09;
        sl_arb_grant   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            msg[i] = 8'hD0 + 8'(i);
            tick();
            wr_evt_type = 8'h9A;
            wr_data     = msg[i];
            wr_valid4   = 1'b1;
            wr_last     = 1'b0;
            #1;
            checks++; if (wr_ready4 !== (i < 4)) begin
                errors++; $display("FAIL trunc_ready[%0d]: got %b, expected %b", i, wr_ready4, (i < 4)); end
            checks++; if (ctr_incr4 !== (i == 3)) begin
                errors++; $display("FAIL trunc_ctr_incr[%0d]: got %b, expected %b", i, ctr_incr4, (i == 3)); end
        end
        checks++; if (sl_addr4 !== 9'h19A || sl_data4 !== 9'h109) begin
            errors++; $display("FAIL trunc_addr: got %h %h, expected 19a 109", sl_addr4, sl_data4); end
        tick();
        wr_valid4 = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin tick(); #1; end
            checks++; if (sl_data4 !== {1'b1, msg[i]}) begin
                errors++; $display("FAIL trunc_data[%0d]: got %h, expected %h", i, sl_data4, {1'b1, msg[i]}); end
        end
        tick(); #1;
        checks++; if (sl_latch_tail4 !== 1'b1 || sl_tail4 !== 9'h104) begin
            errors++; $display("FAIL trunc_tail: got latch %b tail %h, expected 1 104", sl_latch_tail4, sl_tail4); end
        tick(); #1;
        checks++; if (sl_arb_request4 !== 1'b0 || wr_ready4 !== 1'b1) begin
            errors++; $display("FAIL trunc_done: got req %b rdy %b, expected 0 1", sl_arb_request4, wr_ready4); end
    endtask

    task automatic test_reset_mid_frame();
        global_counter = 8'h0A;
        sl_arb_grant   = 1'b1;
        msg[0] = 8'hE1; msg[1] = 8'hE2; msg[2] = 8'hE3;
        write_msg(8'hBC, 3);
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
        tick(); #1;
        checks++; if (sl_addr !== 9'h1BC) begin
            errors++; $display("FAIL rst_addr: got %h, expected 1bc", sl_addr); end
        tick(); #1;
        checks++; if (sl_data !== 9'h1E1) begin
            errors++; $display("FAIL rst_data0: got %h, expected 1e1", sl_data); end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (sl_data !== 9'h1E2) begin
            errors++; $display("FAIL rst_data1: got %h, expected 1e2", sl_data); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if ({sl_addr, sl_data, sl_tail, sl_latch_tail} !== 28'd0 || sl_arb_request !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_after: got bus %h %h %h %b req %b rdy %b busy %b, expected idle", sl_addr, sl_data, sl_tail, sl_latch_tail, sl_arb_request, wr_ready, busy); end
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            checks++; if (sl_latch_tail !== 1'b0 || sl_data !== 9'h000) begin
                errors++; $display("FAIL rst_no_tail[%0d]: got latch %b data %h, expected 0 000", k, sl_latch_tail, sl_data); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_grant_wait();
        test_grant_loss();
        test_overflow();
        test_truncation();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
